instr_compressor: RTL
=====================

INSTR_COMPRESSOR -- requirements
Module: instr_compressor

Interface
REQ-001 SHALL take no parameters; all widths are fixed (instruction 32 bits, parcel 16 bits).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: in_instr is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: an input transfer occurs when in_valid and in_ready are both high.
REQ-006 SHALL have port in_instr, input, 32 bits: uncompressed RV32I instruction; bits [1:0] are 11.
REQ-007 SHALL have port in_last, input, 1 bit: the instruction is the last of its stream and the packer must flush.
REQ-008 SHALL have port out_valid, output, 1 bit: out_word is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: an output transfer occurs when out_valid and out_ready are both high.
REQ-010 SHALL have port out_word, output, 32 bits: packed instruction-memory word; bits [15:0] hold the lower address.
REQ-011 SHALL have port out_last, output, 1 bit: out_word is the final word of the stream.
REQ-012 SHALL have port compressed_cnt, output, 16 bits: number of instructions compressed since reset.

Function
REQ-013 SHALL compress in_instr to 16 bits only when a supported RVC form exists whose standard 32-bit expansion equals in_instr bit-exactly (round-trip rule).
REQ-014 SHALL support exactly these forms: C.LW, C.SW, C.ADDI, C.LI, C.LUI, C.JAL, C.J, C.SRLI, C.SRAI, C.SLLI, C.ANDI, C.SUB, C.XOR, C.OR, C.AND, C.BEQZ, C.BNEZ, C.JR, C.MV, C.JALR, C.ADD.
REQ-015 SHALL enforce the operand limits of those forms:
- x8-x15 for 3-bit register fields;
- immediate and offset ranges and alignment as defined by RVC;
- nonzero shamt below 32;
- reject RVC-reserved and hint encodings: rd=x0, nzimm=0, C.LUI with rd=x2, C.JR/C.JALR with rs1=x0.
REQ-016 SHALL resolve ADDI overlap as follows: C.LI when rs1=x0, otherwise C.ADDI.
REQ-017 SHALL resolve ADD overlap as follows: C.MV when rs1=x0, otherwise C.ADD with rs1=rd.
REQ-018 SHALL implement the packer FSM with three states:
- EMPTY: no pending parcel.
- HALF: a 16-bit parcel is pending.
- FLUSH: a padding word is owed.
REQ-019 SHALL handle a compressed instruction c accepted in EMPTY as follows: store c as pending, go to HALF, emit nothing.
- If in_last is set, instead emit {16'h0001, c} with out_last=1 and stay in EMPTY.
REQ-020 SHALL handle a compressed instruction c accepted in HALF as follows: emit {c, pending} and go to EMPTY; out_last equals in_last.
REQ-021 SHALL handle a 32-bit instruction accepted in EMPTY as follows: emit in_instr unchanged and stay in EMPTY; out_last equals in_last.
REQ-022 SHALL handle a 32-bit instruction accepted in HALF as follows: emit {in_instr[15:0], pending} and set pending to in_instr[31:16].
- Stay in HALF.
- If in_last is set, go to FLUSH with out_last=0.
REQ-023 SHALL, in FLUSH, load {16'h0001, pending} with out_last=1 once the output register is free, then go to EMPTY.
REQ-024 SHALL register the output: a word is produced in the cycle after acceptance, giving 1-cycle latency.
REQ-025 SHALL drive in_ready = (state != FLUSH) && (!out_valid || out_ready).
REQ-026 SHALL hold out_word and out_last stable while out_valid=1 and out_ready=0.
REQ-027 SHALL, when an output transfer and an input acceptance occur in the same cycle, load the new word and keep out_valid=1 without a bubble.
REQ-028 SHALL increment compressed_cnt by 1 per compressed instruction accepted, saturating at 16'hFFFF.

Reset
REQ-029 SHALL, when rst is high at a clock edge, return to EMPTY with these values:
- pending=0, out_valid=0, out_word=0, out_last=0, compressed_cnt=0.
- in_ready=1 in the first cycle after reset.
REQ-030 SHALL, on a reset during HALF or FLUSH, discard the pending parcel without emitting it.

Configuration
REQ-031 SHALL compile the compression logic only when the macro QUINTA_COMPRESS_EN is defined.
REQ-032 SHALL, when QUINTA_COMPRESS_EN is undefined, treat every instruction as uncompressible, so the state never leaves EMPTY.
- Output equals the input stream one word per instruction.
- compressed_cnt stays 0.

Verification
REQ-033 SHALL cover: addi x8,x8,1 (0x00140413) sent twice -> one word 0x04050405, out_last per the second in_last, compressed_cnt=2.
REQ-034 SHALL cover: sub x5,x6,x7 (0x407302B3) in EMPTY with in_last=1 -> 0x407302B3 one cycle later with out_last=1.
REQ-035 SHALL cover: 0x00140413, then 0x407302B3 with in_last=1 -> 0x02B30405, then 0x00014073 with out_last=1; in_ready=0 during FLUSH.
REQ-036 SHALL cover: out_ready held low for 5 cycles with out_valid=1 -> out_word stable and in_ready=0 throughout; no word lost or duplicated.
REQ-037 SHALL cover: rst asserted while in HALF, then 0x407302B3 sent -> output is 0x407302B3 unshifted.
REQ-038 SHALL cover: a build without QUINTA_COMPRESS_EN given 0x00140413 -> emits 0x00140413 unchanged with compressed_cnt=0.

Source files
------------

// File: rtl/instr_compressor.sv
// instr_compressor: converts RV32I instructions to RVC parcels where an exact
// round-trip exists, and packs the resulting 16/32-bit parcels into 32-bit
// instruction-memory words (lower address in bits [15:0]).
// Build option: define QUINTA_COMPRESS_EN to include the compression decoder;
// without it every instruction passes through unchanged.
module instr_compressor (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic        out_last,
    output logic [15:0] compressed_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] pending_reg, pending_next;
    logic        out_valid_reg, out_valid_next;
    logic [31:0] out_word_reg, out_word_next;
    logic        out_last_reg, out_last_next;
    logic [15:0] cnt_reg, cnt_next;

    logic        is_comp;
    logic [15:0] comp_half;
    logic        out_free;
    logic        accept;

`ifdef QUINTA_COMPRESS_EN
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [11:0] i_imm;
    logic [11:0] s_imm;
    logic [12:1] b_off;
    logic [20:1] j_off;
    logic        rd_p, rs1_p, rs2_p;
    logic        i_imm6_ok;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign funct3 = in_instr[14:12];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign funct7 = in_instr[31:25];
    assign i_imm  = in_instr[31:20];
    assign s_imm  = {in_instr[31:25], in_instr[11:7]};
    assign b_off  = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8]};
    assign j_off  = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21]};

    // 3-bit register fields reach only x8..x15 (binary 01xxx)
    assign rd_p  = (rd[4:3]  == 2'b01);
    assign rs1_p = (rs1[4:3] == 2'b01);
    assign rs2_p = (rs2[4:3] == 2'b01);

    // I-immediate fits a signed 6-bit field
    assign i_imm6_ok = (i_imm[11:5] == 7'h00) || (i_imm[11:5] == 7'h7F);

    // Decode: find the RVC form whose expansion equals in_instr exactly
    always_comb begin
        is_comp   = 1'b0;
        comp_half = 16'h0000;
        case (opcode)
            7'b0000011: begin // C.LW
                if (funct3 == 3'b010 && rd_p && rs1_p &&
                    i_imm[11:7] == 5'd0 && i_imm[1:0] == 2'd0) begin
                    is_comp   = 1'b1;
                    comp_half = {3'b010, i_imm[5:3], rs1[2:0], i_imm[2], i_imm[6],
                                 rd[2:0], 2'b00};
                end
            end
            7'b0100011: begin // C.SW
                if (funct3 == 3'b010 && rs1_p && rs2_p &&
                    s_imm[11:7] == 5'd0 && s_imm[1:0] == 2'd0) begin
                    is_comp   = 1'b1;
                    comp_half = {3'b110, s_imm[5:3], rs1[2:0], s_imm[2], s_imm[6],
                                 rs2[2:0], 2'b00};
                end
            end
            7'b0010011: begin
                case (funct3)
                    3'b000: begin // C.LI (rs1=x0) takes priority over C.ADDI
                        if (rd != 5'd0 && i_imm6_ok) begin
                            if (rs1 == 5'd0) begin
                                is_comp   = 1'b1;
                                comp_half = {3'b010, i_imm[5], rd, i_imm[4:0], 2'b01};
                            end else if (rs1 == rd && i_imm != 12'd0) begin
                                is_comp   = 1'b1;
                                comp_half = {3'b000, i_imm[5], rd, i_imm[4:0], 2'b01};
                            end
                        end
                    end
                    3'b001: begin // C.SLLI
                        if (funct7 == 7'd0 && rd == rs1 && rd != 5'd0 && rs2 != 5'd0) begin
                            is_comp   = 1'b1;
                            comp_half = {3'b000, 1'b0, rd, rs2, 2'b10};
                        end
                    end
                    3'b101: begin // C.SRLI / C.SRAI
                        if (rd == rs1 && rd_p && rs2 != 5'd0) begin
                            if (funct7 == 7'b0000000) begin
                                is_comp   = 1'b1;
                                comp_half = {3'b100, 1'b0, 2'b00, rd[2:0], rs2, 2'b01};
                            end else if (funct7 == 7'b0100000) begin
                                is_comp   = 1'b1;
                                comp_half = {3'b100, 1'b0, 2'b01, rd[2:0], rs2, 2'b01};
                            end
                        end
                    end
                    3'b111: begin // C.ANDI
                        if (rd == rs1 && rd_p && i_imm6_ok) begin
                            is_comp   = 1'b1;
                            comp_half = {3'b100, i_imm[5], 2'b10, rd[2:0], i_imm[4:0], 2'b01};
                        end
                    end
                    default: ;
                endcase
            end
            7'b0110111: begin // C.LUI: nonzero 6-bit sign-extended upper immediate
                if (rd != 5'd0 && rd != 5'd2 &&
                    (in_instr[31:17] == 15'h0000 || in_instr[31:17] == 15'h7FFF) &&
                    in_instr[17:12] != 6'd0) begin
                    is_comp   = 1'b1;
                    comp_half = {3'b011, in_instr[17], rd, in_instr[16:12], 2'b01};
                end
            end
            7'b1101111: begin // C.JAL (rd=x1) / C.J (rd=x0), 12-bit signed offset
                if ((rd == 5'd0 || rd == 5'd1) &&
                    (j_off[20:11] == 10'h000 || j_off[20:11] == 10'h3FF)) begin
                    is_comp   = 1'b1;
                    comp_half = {(rd == 5'd1) ? 3'b001 : 3'b101,
                                 j_off[11], j_off[4], j_off[9:8], j_off[10],
                                 j_off[6], j_off[7], j_off[3:1], j_off[5], 2'b01};
                end
            end
            7'b1100011: begin // C.BEQZ / C.BNEZ, 9-bit signed offset
                if ((funct3 == 3'b000 || funct3 == 3'b001) && rs2 == 5'd0 && rs1_p &&
                    (b_off[12:8] == 5'h00 || b_off[12:8] == 5'h1F)) begin
                    is_comp   = 1'b1;
                    comp_half = {(funct3 == 3'b000) ? 3'b110 : 3'b111,
                                 b_off[8], b_off[4:3], rs1[2:0],
                                 b_off[7:6], b_off[2:1], b_off[5], 2'b01};
                end
            end
            7'b1100111: begin // C.JR (rd=x0) / C.JALR (rd=x1), zero offset only
                if (funct3 == 3'b000 && i_imm == 12'd0 && rs1 != 5'd0 &&
                    (rd == 5'd0 || rd == 5'd1)) begin
                    is_comp   = 1'b1;
                    comp_half = {3'b100, rd[0], rs1, 5'd0, 2'b10};
                end
            end
            7'b0110011: begin
                if (funct7 == 7'd0 && funct3 == 3'b000 && rd != 5'd0 && rs2 != 5'd0) begin
                    // C.MV when rs1=x0, else C.ADD requires rs1=rd
                    if (rs1 == 5'd0) begin
                        is_comp   = 1'b1;
                        comp_half = {3'b100, 1'b0, rd, rs2, 2'b10};
                    end else if (rs1 == rd) begin
                        is_comp   = 1'b1;
                        comp_half = {3'b100, 1'b1, rd, rs2, 2'b10};
                    end
                end else if (rd == rs1 && rd_p && rs2_p) begin
                    // C.SUB / C.XOR / C.OR / C.AND share one format
                    if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                        is_comp   = 1'b1;
                        comp_half = {3'b100, 1'b0, 2'b11, rd[2:0], 2'b00, rs2[2:0], 2'b01};
                    end else if (funct7 == 7'd0 && funct3 == 3'b100) begin
                        is_comp   = 1'b1;
                        comp_half = {3'b100, 1'b0, 2'b11, rd[2:0], 2'b01, rs2[2:0], 2'b01};
                    end else if (funct7 == 7'd0 && funct3 == 3'b110) begin
                        is_comp   = 1'b1;
                        comp_half = {3'b100, 1'b0, 2'b11, rd[2:0], 2'b10, rs2[2:0], 2'b01};
                    end else if (funct7 == 7'd0 && funct3 == 3'b111) begin
                        is_comp   = 1'b1;
                        comp_half = {3'b100, 1'b0, 2'b11, rd[2:0], 2'b11, rs2[2:0], 2'b01};
                    end
                end
            end
            default: ;
        endcase
    end
`else
    // Compression compiled out: every instruction is passed through as 32 bits
    assign is_comp   = 1'b0;
    assign comp_half = 16'h0000;
`endif

    assign out_free = !out_valid_reg || out_ready;
    assign in_ready = (state_reg != ST_FLUSH) && out_free;
    assign accept   = in_valid && in_ready;

    assign out_valid      = out_valid_reg;
    assign out_word       = out_word_reg;
    assign out_last       = out_last_reg;
    assign compressed_cnt = cnt_reg;

    // Packer next-state: merge parcels into words, flush the odd half at stream end
    always_comb begin
        state_next     = state_reg;
        pending_next   = pending_reg;
        out_valid_next = out_valid_reg && !out_ready;
        out_word_next  = out_word_reg;
        out_last_next  = out_last_reg;
        cnt_next       = cnt_reg;

        if (accept && is_comp && cnt_reg != 16'hFFFF) begin
            cnt_next = cnt_reg + 16'd1;
        end

        case (state_reg)
            ST_EMPTY: begin
                if (accept) begin
                    if (is_comp) begin
                        if (in_last) begin
                            // lone parcel at stream end: pad with a C.NOP
                            out_valid_next = 1'b1;
                            out_word_next  = {16'h0001, comp_half};
                            out_last_next  = 1'b1;
                        end else begin
                            pending_next = comp_half;
                            state_next   = ST_HALF;
                        end
                    end else begin
                        out_valid_next = 1'b1;
                        out_word_next  = in_instr;
                        out_last_next  = in_last;
                    end
                end
            end
            ST_HALF: begin
                if (accept) begin
                    out_valid_next = 1'b1;
                    if (is_comp) begin
                        out_word_next = {comp_half, pending_reg};
                        out_last_next = in_last;
                        pending_next  = 16'h0000;
                        state_next    = ST_EMPTY;
                    end else begin
                        // 32-bit instruction straddles two words
                        out_word_next = {in_instr[15:0], pending_reg};
                        out_last_next = 1'b0;
                        pending_next  = in_instr[31:16];
                        if (in_last) begin
                            state_next = ST_FLUSH;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                if (out_free) begin
                    out_valid_next = 1'b1;
                    out_word_next  = {16'h0001, pending_reg};
                    out_last_next  = 1'b1;
                    pending_next   = 16'h0000;
                    state_next     = ST_EMPTY;
                end
            end
            default: begin
                state_next = ST_EMPTY;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_EMPTY;
            pending_reg   <= 16'h0000;
            out_valid_reg <= 1'b0;
            out_word_reg  <= 32'h0000_0000;
            out_last_reg  <= 1'b0;
            cnt_reg       <= 16'h0000;
        end else begin
            state_reg     <= state_next;
            pending_reg   <= pending_next;
            out_valid_reg <= out_valid_next;
            out_word_reg  <= out_word_next;
            out_last_reg  <= out_last_next;
            cnt_reg       <= cnt_next;
        end
    end

endmodule
